// File: rtl/tinyalu_cmd_issuer.sv
// tinyalu_cmd_issuer: FIFO-buffered command issuer driving tinyalu start/op/A/B, in-order responses.
// Define TINYALU_ISSUE_TIMEOUT_EN to abort an ISSUE that sees no done within TIMEOUT_CYCLES.
module tinyalu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [7:0]                   cmd_a,
  input  logic [7:0]                   cmd_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [15:0]                  rsp_result,
  output logic [2:0]                   rsp_op,
  output logic                         rsp_err,
  output logic                         alu_start,
  output logic [2:0]                   alu_op,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  input  logic                         alu_done,
  input  logic [15:0]                  alu_result,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2, RESP = 2'd3;
  logic [18:0] mem_q [DEPTH];
  logic [18:0] head;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic start_q, start_d, vld_q, vld_d, err_q, err_d;
  logic [2:0] aop_q, aop_d, rop_q, rop_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [15:0] res_q, res_d;
  logic push, pop, legal, nop, expire;
  assign head = mem_q[rd_q];
  assign legal = head[18:16] inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign nop = head[18:16] == 3'd0 || head[18:16] == 3'd7;
  assign cmd_ready = cnt_q < CW'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = state_q == IDLE && cnt_q != '0;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign fifo_count = cnt_q;
  assign busy = state_q != IDLE || cnt_q != '0;
  assign alu_start = start_q;
  assign alu_op = aop_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign rsp_valid = vld_q;
  assign rsp_result = res_q;
  assign rsp_op = rop_q;
  assign rsp_err = err_q;
`ifdef TINYALU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  assign expire = to_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    to_q <= (!reset_n || state_q != ISSUE) ? '0 : to_q + 1'b1;
`else
  logic unused_to;
  assign unused_to = TIMEOUT_CYCLES > 0;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    aop_d = aop_q;
    a_d = a_q;
    b_d = b_q;
    vld_d = vld_q;
    res_d = res_q;
    rop_d = rop_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (pop) begin
        rop_d = head[18:16];
        if (legal) begin
          aop_d = head[18:16];
          a_d = head[15:8];
          b_d = head[7:0];
          start_d = 1'b1;
          state_d = ISSUE;
        end else begin
          res_d = '0;
          err_d = !nop;
          vld_d = 1'b1;
          state_d = RESP;
        end
      end
      // done arriving on the expiry edge wins over the timeout
      ISSUE: if (alu_done || expire) begin
        res_d = alu_done ? alu_result : '0;
        err_d = !alu_done;
        start_d = 1'b0;
        state_d = GAP;
      end
      GAP: begin
        vld_d = 1'b1;
        state_d = RESP;
      end
      default: if (rsp_ready) begin
        vld_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {cmd_op, cmd_a, cmd_b};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      start_q <= 1'b0;
      aop_q <= '0;
      a_q <= '0;
      b_q <= '0;
      vld_q <= 1'b0;
      res_q <= '0;
      rop_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      start_q <= start_d;
      aop_q <= aop_d;
      a_q <= a_d;
      b_q <= b_d;
      vld_q <= vld_d;
      res_q <= res_d;
      rop_q <= rop_d;
      err_q <= err_d;
    end
  end
endmodule
